// File: rtl/fb_pc_ctrl.sv
// PC next-address / hazard controller with a one-bit RUN/JALR_WAIT FSM.
// Optional performance counters are compiled in with FB_PC_CTRL_PERF_EN.
module fb_pc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cur_pc,
    input  logic        stall_req,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jal_req,
    input  logic [31:0] jal_target,
    input  logic        jalr_req,
    input  logic        jalr_tgt_valid,
    input  logic [31:0] jalr_target,
    output logic [31:0] new_address,
    output logic        pc_write,
    output logic        pc_clear,
    output logic        flush_ifid,
    output logic        bubble,
    output logic        state
`ifdef FB_PC_CTRL_PERF_EN
    ,
    output logic [31:0] redirect_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_JALR_WAIT = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   redirect;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    // NOTE: every output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        new_address = cur_pc;
        pc_write    = 1'b0;
        pc_clear    = 1'b0;
        flush_ifid  = 1'b0;
        bubble      = 1'b0;
        redirect    = 1'b0;

        if (reset) begin
            state_d     = ST_RUN;
            new_address = '0;
            pc_write    = 1'b1;
            flush_ifid  = 1'b1;
            bubble      = 1'b1;
        end else if (br_taken) begin
            // A taken branch wins in both states and abandons any pending JALR.
            state_d     = ST_RUN;
            new_address = br_target;
            flush_ifid  = 1'b1;
            bubble      = 1'b1;
            redirect    = 1'b1;
        end else if (state_q == ST_JALR_WAIT) begin
            if (jalr_tgt_valid) begin
                state_d     = ST_RUN;
                new_address = jalr_target;
                flush_ifid  = 1'b1;
                redirect    = 1'b1;
            end else begin
                pc_write = 1'b1;
                bubble   = 1'b1;
            end
        end else if (jalr_req) begin
            state_d  = ST_JALR_WAIT;
            pc_write = 1'b1;
            pc_clear = 1'b1;
        end else if (jal_req) begin
            new_address = jal_target;
            flush_ifid  = 1'b1;
            redirect    = 1'b1;
        end else if (stall_req) begin
            pc_write = 1'b1;
            bubble   = 1'b1;
        end else begin
            new_address = cur_pc + 32'd1;
        end
    end

    assign state = state_q;

`ifdef FB_PC_CTRL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if (!pc_write && redirect) redirect_cnt <= redirect_cnt + 32'd1;
            if (pc_write)              stall_cnt    <= stall_cnt + 32'd1;
        end
    end
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_fb_pc_ctrl.sv
// Self-checking bench for fb_pc_ctrl: directed scenarios plus randomized traffic
// checked every cycle against an action-table reference model.
module tb_fb_pc_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cur_pc = '0;
    logic        stall_req = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        jal_req = 1'b0;
    logic [31:0] jal_target = '0;
    logic        jalr_req = 1'b0;
    logic        jalr_tgt_valid = 1'b0;
    logic [31:0] jalr_target = '0;
    logic [31:0] new_address;
    logic        pc_write, pc_clear, flush_ifid, bubble, state;
`ifdef FB_PC_CTRL_PERF_EN
    logic [31:0] redirect_cnt, stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    fb_pc_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .cur_pc         (cur_pc),
        .stall_req      (stall_req),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .jal_req        (jal_req),
        .jal_target     (jal_target),
        .jalr_req       (jalr_req),
        .jalr_tgt_valid (jalr_tgt_valid),
        .jalr_target    (jalr_target),
        .new_address    (new_address),
        .pc_write       (pc_write),
        .pc_clear       (pc_clear),
        .flush_ifid     (flush_ifid),
        .bubble         (bubble),
        .state          (state)
`ifdef FB_PC_CTRL_PERF_EN
        ,
        .redirect_cnt   (redirect_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {A_RESET, A_BRANCH, A_JALR_START, A_JAL, A_STALL, A_SEQ, A_JALR_DONE, A_JALR_HOLD} act_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        pw, clr, flush, bub, wait_next, redirect;
        logic        chk_addr, chk_flush, chk_bub;
    } exp_t;

    bit   m_wait     = 1'b0;
    bit   m_wait_nxt = 1'b0;
    exp_t m_exp      = '0;
    int unsigned m_redir = 0;
    int unsigned m_stall = 0;

    function automatic act_t pick(bit waiting);
        if (reset)    return A_RESET;
        if (br_taken) return A_BRANCH;
        if (waiting)  return jalr_tgt_valid ? A_JALR_DONE : A_JALR_HOLD;
        if (jalr_req) return A_JALR_START;
        if (jal_req)  return A_JAL;
        if (stall_req) return A_STALL;
        return A_SEQ;
    endfunction

    // Fields: addr, pw, clr, flush, bub, wait_next, redirect, chk_addr, chk_flush, chk_bub
    function automatic exp_t outcome(act_t a);
        case (a)
            A_RESET:      return '{32'h0,         1, 0, 1, 1, 0, 0, 1, 1, 1};
            A_BRANCH:     return '{br_target,     0, 0, 1, 1, 0, 1, 1, 1, 1};
            A_JALR_START: return '{cur_pc,        1, 1, 0, 0, 1, 0, 0, 0, 1};
            A_JAL:        return '{jal_target,    0, 0, 1, 0, 0, 1, 1, 1, 0};
            A_STALL:      return '{cur_pc,        1, 0, 0, 1, 0, 0, 1, 1, 1};
            A_JALR_DONE:  return '{jalr_target,   0, 0, 1, 0, 0, 1, 1, 1, 0};
            A_JALR_HOLD:  return '{cur_pc,        1, 0, 0, 1, 1, 0, 0, 0, 1};
            default:      return '{cur_pc + 32'd1, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        endcase
    endfunction

    // Single compare process: checks all outputs mid-cycle against the model.
    always @(negedge clk) begin
        exp_t e;
        e = outcome(pick(m_wait));
        check("pc_write", {31'b0, pc_write}, {31'b0, e.pw});
        check("pc_clear", {31'b0, pc_clear}, {31'b0, e.clr});
        check("state",    {31'b0, state},    {31'b0, m_wait});
        if (e.chk_addr)  check("new_address", new_address, e.addr);
        if (e.chk_flush) check("flush_ifid", {31'b0, flush_ifid}, {31'b0, e.flush});
        if (e.chk_bub)   check("bubble", {31'b0, bubble}, {31'b0, e.bub});
`ifdef FB_PC_CTRL_PERF_EN
        check("redirect_cnt", redirect_cnt, m_redir);
        check("stall_cnt",    stall_cnt,    m_stall);
`endif
        m_wait_nxt = e.wait_next;
        m_exp      = e;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_wait  = 1'b0;
            m_redir = 0;
            m_stall = 0;
        end else begin
            m_wait = m_wait_nxt;
            if (!m_exp.pw && m_exp.redirect) m_redir = m_redir + 1;
            if (m_exp.pw)                    m_stall = m_stall + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_req      = 1'b0;
        br_taken       = 1'b0;
        jal_req        = 1'b0;
        jalr_req       = 1'b0;
        jalr_tgt_valid = 1'b0;
    endtask

    initial begin
        int clr_pulses;

        // Reset values while reset is held.
        #3;
        check("rst_pc_write", {31'b0, pc_write},   32'd1);
        check("rst_pc_clear", {31'b0, pc_clear},   32'd0);
        check("rst_flush",    {31'b0, flush_ifid}, 32'd1);
        check("rst_bubble",   {31'b0, bubble},     32'd1);
        check("rst_addr",     new_address,         32'h0);
        check("rst_state",    {31'b0, state},      32'd0);

        // Sequential wrap right after reset release.
        step();
        step();
        reset  = 1'b0;
        cur_pc = 32'hFFFF_FFFF;
        #2;
        check("wrap_addr", new_address,        32'h0000_0000);
        check("wrap_pw",   {31'b0, pc_write},  32'd0);

        // Branch beats JAL and stall in the same cycle.
        step();
        br_taken = 1'b1; br_target = 32'h40; jal_req = 1'b1; jal_target = 32'h99; stall_req = 1'b1;
        #2;
        check("prio_addr",  new_address,         32'h40);
        check("prio_pw",    {31'b0, pc_write},   32'd0);
        check("prio_flush", {31'b0, flush_ifid}, 32'd1);
        check("prio_bub",   {31'b0, bubble},     32'd1);

        // JALR: one clear pulse, four held cycles, then redirect.
        step();
        clear_inputs();
        cur_pc = 32'h100;
        jalr_req = 1'b1;
        #2;
        clr_pulses = int'(pc_clear);
        check("jalr_pw0", {31'b0, pc_write}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            clear_inputs();
            jal_req = 1'b1; jal_target = 32'h77; stall_req = 1'b1;
            #2;
            clr_pulses += int'(pc_clear);
            check("jalr_hold_pw",    {31'b0, pc_write}, 32'd1);
            check("jalr_hold_state", {31'b0, state},    32'd1);
        end
        step();
        clear_inputs();
        jalr_tgt_valid = 1'b1; jalr_target = 32'h80;
        #2;
        clr_pulses += int'(pc_clear);
        check("jalr_addr",   new_address,       32'h80);
        check("jalr_pw",     {31'b0, pc_write}, 32'd0);
        check("jalr_pulses", clr_pulses,        32'd1);
        step();
        clear_inputs();
        #2;
        check("jalr_ret_state", {31'b0, state}, 32'd0);

        // Branch overrides a simultaneously valid JALR target.
        step();
        jalr_req = 1'b1;
        step();
        clear_inputs();
        br_taken = 1'b1; br_target = 32'h10; jalr_tgt_valid = 1'b1; jalr_target = 32'h80;
        #2;
        check("brjalr_addr", new_address, 32'h10);
        step();
        clear_inputs();
        #2;
        check("brjalr_state", {31'b0, state}, 32'd0);

        // Asynchronous reset mid-JALR_WAIT.
        step();
        jalr_req = 1'b1;
        step();
        clear_inputs();
        #1;
        check("pre_arst_state", {31'b0, state}, 32'd1);
        reset = 1'b1;
        #1;
        check("arst_state", {31'b0, state},    32'd0);
        check("arst_pw",    {31'b0, pc_write}, 32'd1);
        step();
        reset = 1'b0;

`ifdef FB_PC_CTRL_PERF_EN
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_inputs();
        stall_req = 1'b1;
        step();
        step();
        clear_inputs();
        jal_req = 1'b1; jal_target = 32'h5;
        step();
        clear_inputs();
        #2;
        check("perf_stall",    stall_cnt,    32'd2);
        check("perf_redirect", redirect_cnt, 32'd1);
`endif

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            step();
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 99) == 0) reset = 1'b1;
            cur_pc         = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            br_taken       = ($urandom_range(0, 7) == 0);
            br_target      = $urandom;
            jalr_req       = ($urandom_range(0, 5) == 0);
            jal_req        = ($urandom_range(0, 5) == 0);
            jal_target     = $urandom;
            stall_req      = ($urandom_range(0, 3) == 0);
            jalr_tgt_valid = ($urandom_range(0, 2) == 0);
            jalr_target    = $urandom;
        end
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
